// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - op encodings, FSM states and op-decode helpers for mdu_iter
package mdu_iter_pkg;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/result bundle between the execute-stage ALU and mdu_iter
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             cancel_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_zero_o;

  modport master (
    output start_i, cancel_i, op_i, a_i, b_i,
    input  busy_o, done_o, hi_o, lo_o, div_zero_o
  );

  modport slave (
    input  start_i, cancel_i, op_i, a_i, b_i,
    output busy_o, done_o, hi_o, lo_o, div_zero_o
  );
endinterface

// File: rtl/mdu_iter_div_step.sv
// rtl/mdu_iter_div_step.sv - one combinational restoring-division step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor, so the shifted value fits WIDTH+1 bits and a borrow shows up in the MSB
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply/divide unit with {hi,lo} result
// MDU_FAST_MUL_EN: multiplies complete at the capture edge through a full-width multiplier.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, sh_q, opnd_q, hi_q, lo_q;
  logic             is_div_q, sign_q, rem_sign_q;
  logic             busy_q, done_q, dz_q;

  logic             sa_d, sb_d, accept_d;
  logic [WIDTH-1:0] a_abs_d, b_abs_d, div_rem_d;
  logic             div_q_d;
  logic [WIDTH:0]   mul_sum_d;
  logic [2*WIDTH-1:0] prod_fix_d;

  assign sa_d     = op_is_signed(bus.op_i) & bus.a_i[WIDTH-1];
  assign sb_d     = op_is_signed(bus.op_i) & bus.b_i[WIDTH-1];
  assign a_abs_d  = sa_d ? -bus.a_i : bus.a_i;
  assign b_abs_d  = sb_d ? -bus.b_i : bus.b_i;
  assign accept_d = bus.start_i & ~bus.cancel_i & (state_q == ST_IDLE || state_q == ST_DONE);

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (acc_q),
    .divisor_i (opnd_q),
    .bit_i     (sh_q[WIDTH-1]),
    .rem_o     (div_rem_d),
    .q_o       (div_q_d)
  );

  // Shift-add multiply: acc_q holds the running high half, sh_q the multiplier/low half
  assign mul_sum_d  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
  assign prod_fix_d = sign_q ? -{acc_q, sh_q} : {acc_q, sh_q};

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] a_ext_d, b_ext_d, fast_prod_d;
  assign a_ext_d     = {{WIDTH{op_is_signed(bus.op_i) & bus.a_i[WIDTH-1]}}, bus.a_i};
  assign b_ext_d     = {{WIDTH{op_is_signed(bus.op_i) & bus.b_i[WIDTH-1]}}, bus.b_i};
  assign fast_prod_d = a_ext_d * b_ext_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      acc_q <= '0; sh_q <= '0; opnd_q <= '0; hi_q <= '0; lo_q <= '0;
      is_div_q <= 1'b0; sign_q <= 1'b0; rem_sign_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; dz_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (accept_d) begin
            dz_q       <= 1'b0;
            is_div_q   <= op_is_div(bus.op_i);
            sign_q     <= sa_d ^ sb_d;
            rem_sign_q <= sa_d;
            acc_q      <= '0;
            sh_q       <= op_is_div(bus.op_i) ? a_abs_d : b_abs_d;
            opnd_q     <= op_is_div(bus.op_i) ? b_abs_d : a_abs_d;
            if (op_is_div(bus.op_i) && bus.b_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
              hi_q    <= bus.a_i;
              lo_q    <= '1;
`ifdef MDU_FAST_MUL_EN
            end else if (!op_is_div(bus.op_i)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              {hi_q, lo_q} <= fast_prod_d;
`endif
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(WIDTH);
            end
          end
        end
        ST_CALC: begin
          if (bus.cancel_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              acc_q <= div_rem_d;
              sh_q  <= {sh_q[WIDTH-2:0], div_q_d};
            end else begin
              acc_q <= mul_sum_d[WIDTH:1];
              sh_q  <= {mul_sum_d[0], sh_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy_q <= 1'b0;
          if (bus.cancel_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            if (is_div_q) begin
              lo_q <= sign_q ? -sh_q : sh_q;
              hi_q <= rem_sign_q ? -acc_q : acc_q;
            end else begin
              {hi_q, lo_q} <= prod_fix_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.div_zero_o = dz_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
endmodule
